// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max-pool over a raster-order pixel stream; one pooled pixel per 2x2 block.
// Latency: exactly 1 cycle from the accepting edge of the block's bottom-right pixel.
// Backpressure: none; in_valid low simply stalls all state, out_valid is a single-cycle pulse.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid         in_pixel is consumed this cycle
//   in_pixel         unsigned input pixel, raster order
//   out_valid        out_pixel/out_last valid this cycle
//   out_pixel        pooled maximum, holds its value while out_valid is low
//   out_last         final pooled pixel of the frame
module maxpool_2x2 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 10,
  parameter int NUM_ROWS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_last
);

  localparam int HALF_COLS = ROW_SIZE / 2;
  localparam int HALF_ROWS = NUM_ROWS / 2;
  localparam int CW        = $clog2(ROW_SIZE);
  localparam int RW        = $clog2(NUM_ROWS);
  localparam int LBW       = (HALF_COLS > 1) ? $clog2(HALF_COLS) : 1;

  localparam logic [CW-1:0] COL_MAX       = CW'(ROW_SIZE - 1);
  localparam logic [CW-1:0] LAST_PAIR_COL = CW'(2 * HALF_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX       = RW'(NUM_ROWS - 1);
  localparam logic [RW-1:0] LAST_PAIR_ROW = RW'(2 * HALF_ROWS - 1);
  localparam bit            ODD_COLS      = (ROW_SIZE % 2) != 0;
  localparam bit            ODD_ROWS      = (NUM_ROWS % 2) != 0;

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
  logic                 out_last_q, out_last_d;

  // One entry per horizontal pair; not reset because every entry is
  // written on an even row before the following odd row reads it.
  logic [WORD_SIZE-1:0] lb_q [HALF_COLS];

  logic                 col_in_pair;
  logic                 row_in_pair;
  logic                 pair_col;
  logic                 lb_we;
  logic                 emit;
  logic [LBW-1:0]       lb_idx;
  logic [WORD_SIZE-1:0] pair_max;
  logic [WORD_SIZE-1:0] lb_rd;
  logic [WORD_SIZE-1:0] result;

  // The trailing column/row of an odd dimension belongs to no 2x2 block.
  assign col_in_pair = !(ODD_COLS && (col_q == COL_MAX));
  assign row_in_pair = !(ODD_ROWS && (row_q == ROW_MAX));

  assign lb_idx   = LBW'(col_q >> 1);
  assign pair_max = (hold_q > in_pixel) ? hold_q : in_pixel;
  assign lb_rd    = lb_q[lb_idx];
  assign result   = (lb_rd > pair_max) ? lb_rd : pair_max;

  assign pair_col = in_valid && col_q[0] && col_in_pair;
  assign lb_we    = pair_col && !row_q[0] && row_in_pair;
  // An odd row index is never the discarded trailing row, so no row_in_pair here.
  assign emit     = pair_col && row_q[0];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = emit;
    out_pixel_d = out_pixel_q;
    out_last_d  = 1'b0;

    if (in_valid) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0] && col_in_pair) begin
        hold_d = in_pixel;
      end
    end

    if (emit) begin
      out_pixel_d = result;
      out_last_d  = (row_q == LAST_PAIR_ROW) && (col_q == LAST_PAIR_COL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair_max;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       out_last;

  logic       odd_in_valid = 1'b0;
  logic [7:0] odd_in_pixel = '0;
  logic       odd_out_valid;
  logic [7:0] odd_out_pixel;
  logic       odd_out_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(10), .NUM_ROWS(10)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_last  (out_last)
  );

  maxpool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5), .NUM_ROWS(5)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (odd_in_valid),
    .in_pixel  (odd_in_pixel),
    .out_valid (odd_out_valid),
    .out_pixel (odd_out_pixel),
    .out_last  (odd_out_last)
  );

  // Drive one cycle on the 10x10 instance, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] p);
    in_valid = v;
    in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic step_odd(input logic v, input logic [7:0] p);
    odd_in_valid = v;
    odd_in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_pixel !== 8'd0) $display("FAIL reset_out_pixel: got %0d expected 0", out_pixel); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else n_pass++;
    n_checks++; if (odd_out_valid !== 1'b0) $display("FAIL reset_odd_valid: got %b expected 0", odd_out_valid); else n_pass++;
    n_checks++; if (odd_out_pixel !== 8'd0) $display("FAIL reset_odd_pixel: got %0d expected 0", odd_out_pixel); else n_pass++;
    rst = 1'b0;
  endtask

  // pixel = r*10+c: each block's max is its bottom-right pixel.
  task automatic test_basic();
    int nout = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic ev;
        ev = (r % 2 == 1) && (c % 2 == 1);
        step(1'b1, 8'(r * 10 + c));
        n_checks++;
        if (out_valid !== ev) $display("FAIL basic_valid r%0d c%0d: got %b expected %b", r, c, out_valid, ev);
        else n_pass++;
        if (ev) begin
          nout++;
          n_checks++;
          if (out_pixel !== 8'(r * 10 + c)) $display("FAIL basic_pixel r%0d c%0d: got %0d expected %0d", r, c, out_pixel, r * 10 + c);
          else n_pass++;
          n_checks++;
          if (out_last !== (r == 9 && c == 9)) $display("FAIL basic_last r%0d c%0d: got %b", r, c, out_last);
          else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 25) $display("FAIL basic_count: got %0d expected 25", nout); else n_pass++;
  endtask

  task automatic test_quadrant();
    logic [7:0] img [10][10];
    logic [7:0] exp_out [25];
    int k = 0;
    for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) img[r][c] = 8'd0;
    for (int i = 0; i < 25; i++) exp_out[i] = 8'd0;
    // Block k: rows 0-1, cols 2k..2k+1, given as {TL, TR, BL, BR}.
    img[0][0] = 200; img[0][1] = 3;   img[1][0] = 4;   img[1][1] = 5;
    img[0][2] = 3;   img[0][3] = 200; img[1][2] = 4;   img[1][3] = 5;
    img[0][4] = 3;   img[0][5] = 4;   img[1][4] = 200; img[1][5] = 5;
    img[0][6] = 3;   img[0][7] = 4;   img[1][6] = 5;   img[1][7] = 200;
    img[0][8] = 255; img[0][9] = 255; img[1][8] = 255; img[1][9] = 255;
    exp_out[0] = 200; exp_out[1] = 200; exp_out[2] = 200; exp_out[3] = 200; exp_out[4] = 255;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        step(1'b1, img[r][c]);
        if (out_valid === 1'b1) begin
          if (k < 25) begin
            n_checks++;
            if (out_pixel !== exp_out[k]) $display("FAIL quad_pixel #%0d: got %0d expected %0d", k, out_pixel, exp_out[k]);
            else n_pass++;
          end
          k++;
        end
      end
    end
    n_checks++; if (k != 25) $display("FAIL quad_count: got %0d expected 25", k); else n_pass++;
  endtask

  task automatic test_bubbles();
    logic [7:0] held = 8'd0;
    int nout = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic ev;
        for (int b = 0; b < 6 && $urandom_range(99, 0) < 40; b++) begin
          step(1'b0, 8'hA5);
          n_checks++;
          if (out_valid !== 1'b0) $display("FAIL bubble_valid r%0d c%0d: got %b expected 0", r, c, out_valid);
          else n_pass++;
          n_checks++;
          if (out_pixel !== held) $display("FAIL bubble_hold r%0d c%0d: got %0d expected %0d", r, c, out_pixel, held);
          else n_pass++;
        end
        ev = (r % 2 == 1) && (c % 2 == 1);
        step(1'b1, 8'(r * 10 + c));
        n_checks++;
        if (out_valid !== ev) $display("FAIL bubble_acc_valid r%0d c%0d: got %b expected %b", r, c, out_valid, ev);
        else n_pass++;
        if (ev) begin
          held = 8'(r * 10 + c);
          nout++;
          n_checks++;
          if (out_pixel !== held) $display("FAIL bubble_pixel r%0d c%0d: got %0d expected %0d", r, c, out_pixel, held);
          else n_pass++;
          n_checks++;
          if (out_last !== (r == 9 && c == 9)) $display("FAIL bubble_last r%0d c%0d: got %b", r, c, out_last);
          else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 25) $display("FAIL bubble_count: got %0d expected 25", nout); else n_pass++;
  endtask

  // Frame A ascending then frame B descending with no gap; B's block max is its top-left pixel.
  task automatic test_back_to_back();
    int nlast = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 10; r++) begin
        for (int c = 0; c < 10; c++) begin
          logic ev;
          int   ep;
          ev = (r % 2 == 1) && (c % 2 == 1);
          ep = (f == 0) ? (r * 10 + c) : (99 - ((r - 1) * 10 + (c - 1)));
          step(1'b1, (f == 0) ? 8'(r * 10 + c) : 8'(99 - (r * 10 + c)));
          if (out_last === 1'b1) nlast++;
          n_checks++;
          if (out_valid !== ev) $display("FAIL b2b_valid f%0d r%0d c%0d: got %b expected %b", f, r, c, out_valid, ev);
          else n_pass++;
          if (ev) begin
            n_checks++;
            if (out_pixel !== 8'(ep)) $display("FAIL b2b_pixel f%0d r%0d c%0d: got %0d expected %0d", f, r, c, out_pixel, ep);
            else n_pass++;
          end
        end
      end
    end
    n_checks++; if (nlast != 2) $display("FAIL b2b_last_count: got %0d expected 2", nlast); else n_pass++;
  endtask

  // 5x5 frame, pixel = r*5+c: expected 6, 8, 16, 18; column 4 and row 4 yield nothing.
  task automatic test_odd_dims();
    int nout = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        logic ev;
        ev = (r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4);
        step_odd(1'b1, 8'(r * 5 + c));
        n_checks++;
        if (odd_out_valid !== ev) $display("FAIL odd_valid r%0d c%0d: got %b expected %b", r, c, odd_out_valid, ev);
        else n_pass++;
        if (ev) begin
          nout++;
          n_checks++;
          if (odd_out_pixel !== 8'(r * 5 + c)) $display("FAIL odd_pixel r%0d c%0d: got %0d expected %0d", r, c, odd_out_pixel, r * 5 + c);
          else n_pass++;
          n_checks++;
          if (odd_out_last !== (r == 3 && c == 3)) $display("FAIL odd_last r%0d c%0d: got %b", r, c, odd_out_last);
          else n_pass++;
        end
      end
    end
    step_odd(1'b0, 8'd0);
    n_checks++; if (nout != 4) $display("FAIL odd_count: got %0d expected 4", nout); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int nout = 0;
    // 37 bright pixels leave stale 250s in the line buffer and the counters mid-row.
    for (int i = 0; i < 37; i++) step(1'b1, 8'd250);
    rst = 1'b1;
    step(1'b0, 8'd0);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_pixel !== 8'd0) $display("FAIL rstmid_pixel: got %0d expected 0", out_pixel); else n_pass++;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic ev;
        ev = (r % 2 == 1) && (c % 2 == 1);
        step(1'b1, 8'(r * 10 + c));
        n_checks++;
        if (out_valid !== ev) $display("FAIL rstmid_frame_valid r%0d c%0d: got %b expected %b", r, c, out_valid, ev);
        else n_pass++;
        if (ev) begin
          nout++;
          n_checks++;
          if (out_pixel !== 8'(r * 10 + c)) $display("FAIL rstmid_frame_pixel r%0d c%0d: got %0d expected %0d", r, c, out_pixel, r * 10 + c);
          else n_pass++;
        end
      end
    end
    step(1'b0, 8'd0);
    n_checks++; if (nout != 25) $display("FAIL rstmid_count: got %0d expected 25", nout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quadrant();
    test_bubbles();
    test_back_to_back();
    step(1'b0, 8'd0);
    test_odd_dims();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
